// File: rtl/e_mul_div_unit_pkg.sv
`default_nettype none
// ==========================================================================
// e_mul_div_unit_pkg: md_op codes, state/class types; MDU_MADD_EN adds MADD family.
// Rev 1.0
// ==========================================================================
package e_mul_div_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_MTHI = 3'd1,
    CLS_MTLO = 3'd2,
    CLS_MULT = 3'd3,
    CLS_DIV  = 3'd4
  } md_class_e;

  // Disabled MADD-family codes fall into CLS_NONE, so they behave like MD_NONE.
  function automatic md_class_e md_class(input logic [3:0] op);
    md_class_e cls;
    cls = CLS_NONE;
    case (op)
      MD_MULT, MD_MULTU: cls = CLS_MULT;
      MD_DIV, MD_DIVU:   cls = CLS_DIV;
      MD_MTHI:           cls = CLS_MTHI;
      MD_MTLO:           cls = CLS_MTLO;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: cls = CLS_MULT;
`endif
      default:           cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/e_mul_div_unit_if.sv
`default_nettype none
// ==========================================================================
// e_mul_div_unit_if: E-stage request/operand and HI/LO/busy bundle for the MDU.
// Rev 1.0
// ==========================================================================
interface e_mul_div_unit_if;
  logic        req;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output req, start, md_op, rs_val, rt_val,
    input  busy, hi_out, lo_out
  );

  modport slave (
    input  req, start, md_op, rs_val, rt_val,
    output busy, hi_out, lo_out
  );
endinterface
`default_nettype wire

// File: rtl/e_mul_div_unit_mdu_core.sv
`default_nettype none
// ==========================================================================
// mdu_core: combinational mult/div (and MADD family when MDU_MADD_EN) datapath.
// Rev 1.0
// ==========================================================================
module mdu_core
  import e_mul_div_unit_pkg::*;
(
  input  logic [3:0]  md_op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
`ifdef MDU_MADD_EN
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
`endif
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        div0_o
);

  logic        mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic        div_signed;
  logic        is_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quot;
  logic [31:0] rem;
`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_i, lo_i};
`endif

  assign mul_signed = (md_op_i == MD_MULT) || (md_op_i == MD_MADD) || (md_op_i == MD_MSUB);
  assign mul_a      = mul_signed ? {{32{rs_i[31]}}, rs_i} : {32'd0, rs_i};
  assign mul_b      = mul_signed ? {{32{rt_i[31]}}, rt_i} : {32'd0, rt_i};
  // Low 64 bits of the extended product are exact for both signed and unsigned.
  assign prod       = mul_a * mul_b;

  assign div_signed = (md_op_i == MD_DIV);
  assign is_div     = (md_op_i == MD_DIV) || (md_op_i == MD_DIVU);
  assign a_neg      = div_signed & rs_i[31];
  assign b_neg      = div_signed & rt_i[31];
  assign mag_a      = a_neg ? (32'd0 - rs_i) : rs_i;
  assign mag_b      = b_neg ? (32'd0 - rt_i) : rt_i;
  assign safe_b     = (rt_i == 32'd0) ? 32'd1 : mag_b;
  assign uq         = mag_a / safe_b;
  assign ur         = mag_a % safe_b;
  assign quot       = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem        = a_neg ? (32'd0 - ur) : ur;
  assign div0_o     = is_div && (rt_i == 32'd0);

  always_comb begin
    res_hi_o = prod[63:32];
    res_lo_o = prod[31:0];
    case (md_op_i)
      MD_DIV, MD_DIVU: begin
        res_hi_o = rem;
        res_lo_o = quot;
      end
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: {res_hi_o, res_lo_o} = acc + prod;
      MD_MSUB, MD_MSUBU: {res_hi_o, res_lo_o} = acc - prod;
`endif
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/e_mul_div_unit.sv
`default_nettype none
// ==========================================================================
// e_mul_div_unit: E-stage HI/LO unit with busy counter; MDU_MADD_EN enables MADD family.
// Rev 1.0
// ==========================================================================
module e_mul_div_unit
  import e_mul_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  e_mul_div_unit_if.slave    md_if
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       thi_q, thi_d;
  logic [31:0]       tlo_q, tlo_d;
  logic              div0_q, div0_d;
  logic [31:0]       core_hi;
  logic [31:0]       core_lo;
  logic              core_div0;

  mdu_core u_core (
    .md_op_i  (md_if.md_op),
    .rs_i     (md_if.rs_val),
    .rt_i     (md_if.rt_val),
`ifdef MDU_MADD_EN
    .hi_i     (hi_q),
    .lo_i     (lo_q),
`endif
    .res_hi_o (core_hi),
    .res_lo_o (core_lo),
    .div0_o   (core_div0)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      thi_q   <= '0;
      tlo_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      thi_q   <= thi_d;
      tlo_q   <= tlo_d;
      div0_q  <= div0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    thi_d   = thi_q;
    tlo_d   = tlo_q;
    div0_d  = div0_q;
    unique case (state_q)
      ST_IDLE: begin
        if (md_if.start && !md_if.req) begin
          case (md_class(md_if.md_op))
            CLS_MTHI: hi_d = md_if.rs_val;
            CLS_MTLO: lo_d = md_if.rs_val;
            CLS_MULT: begin
              thi_d   = core_hi;
              tlo_d   = core_lo;
              div0_d  = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = ST_BUSY;
            end
            CLS_DIV: begin
              thi_d   = core_hi;
              tlo_d   = core_lo;
              div0_d  = core_div0;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = ST_BUSY;
            end
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        // req is ignored here: the op in flight belongs to a committed instruction.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (!div0_q) begin
            hi_d = thi_q;
            lo_d = tlo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign md_if.busy   = (state_q == ST_BUSY);
  assign md_if.hi_out = hi_q;
  assign md_if.lo_out = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_e_mul_div_unit.sv
`default_nettype none
// tb_e_mul_div_unit: directed vectors, arithmetic reference model checked every cycle.
module tb_e_mul_div_unit;
  import e_mul_div_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  e_mul_div_unit_if md_if();

  e_mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md_if (md_if)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: committed HI/LO, a pending result and the busy cycles left.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_ok;
  int          m_left = 0;
  bit          armed = 0;

  task automatic model_accept(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint      sa, sb;
    logic [63:0] ua, ub, r64, acc;
    sa  = longint'($signed(rs));
    sb  = longint'($signed(rt));
    ua  = {32'd0, rs};
    ub  = {32'd0, rt};
    acc = {m_hi, m_lo};
    p_ok = 1'b1;
    case (op)
      MD_MTHI: m_hi = rs;
      MD_MTLO: m_lo = rs;
      MD_MULT:  begin r64 = 64'(sa * sb); {p_hi, p_lo} = r64; m_left = MC; end
      MD_MULTU: begin r64 = ua * ub;      {p_hi, p_lo} = r64; m_left = MC; end
      MD_DIV: begin
        m_left = DC;
        if (rt == 0) p_ok = 1'b0;
        else begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
      end
      MD_DIVU: begin
        m_left = DC;
        if (rt == 0) p_ok = 1'b0;
        else begin p_lo = rs / rt; p_hi = rs % rt; end
      end
`ifdef MDU_MADD_EN
      MD_MADD:  begin r64 = acc + 64'(sa * sb); {p_hi, p_lo} = r64; m_left = MC; end
      MD_MADDU: begin r64 = acc + ua * ub;      {p_hi, p_lo} = r64; m_left = MC; end
      MD_MSUB:  begin r64 = acc - 64'(sa * sb); {p_hi, p_lo} = r64; m_left = MC; end
      MD_MSUBU: begin r64 = acc - ua * ub;      {p_hi, p_lo} = r64; m_left = MC; end
`endif
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; m_left = 0; armed = 1;
    end else if (armed) begin
      if (m_left != 0) begin
        if (md_if.start) begin
          checks++; errors++;
          $display("FAIL start_while_busy: start=1 with %0d busy cycles left", m_left);
        end
        m_left--;
        if (m_left == 0 && p_ok) begin m_hi = p_hi; m_lo = p_lo; end
      end else if (md_if.start && !md_if.req) begin
        model_accept(md_if.md_op, md_if.rs_val, md_if.rt_val);
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("cyc_busy", {31'd0, md_if.busy}, {31'd0, (m_left != 0)});
      chk("cyc_hi", md_if.hi_out, m_hi);
      chk("cyc_lo", md_if.lo_out, m_lo);
    end
  end

  // Presents one op for one edge; returns at the negedge after that edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic rq);
    @(negedge clk);
    md_if.start = 1'b1; md_if.md_op = op; md_if.rs_val = rs; md_if.rt_val = rt; md_if.req = rq;
    @(negedge clk);
    md_if.start = 1'b0; md_if.md_op = MD_NONE; md_if.req = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (md_if.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still %b after %0d cycles", md_if.busy, n);
    end
  endtask

  int n;

  initial begin
    md_if.start = 1'b0; md_if.req = 1'b0; md_if.md_op = MD_NONE;
    md_if.rs_val = 0; md_if.rt_val = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_hi", md_if.hi_out, 32'h0);
    chk("rst_lo", md_if.lo_out, 32'h0);
    chk("rst_busy", {31'd0, md_if.busy}, 32'h0);

    issue(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0); wait_idle(n);
    chk("mult_cycles", n, MC);
    chk("mult_hi", md_if.hi_out, 32'hFFFFFFFF);
    chk("mult_lo", md_if.lo_out, 32'hFFFFFFFA);

    issue(MD_DIVU, 32'd7, 32'd2, 1'b0); wait_idle(n);
    chk("divu_cycles", n, DC);
    chk("divu_lo", md_if.lo_out, 32'd3);
    chk("divu_hi", md_if.hi_out, 32'd1);

    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0); wait_idle(n);
    chk("div_lo", md_if.lo_out, 32'hFFFFFFFD);
    chk("div_hi", md_if.hi_out, 32'hFFFFFFFF);

    issue(MD_MTLO, 32'h1234, 32'd0, 1'b1); wait_idle(n);
    chk("mtlo_req_lo", md_if.lo_out, 32'hFFFFFFFD);
    issue(MD_MULT, 32'd9, 32'd9, 1'b1); wait_idle(n);
    chk("mult_req_busy", n, 0);
    chk("mult_req_lo", md_if.lo_out, 32'hFFFFFFFD);

    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0); wait_idle(n);
    chk("ovf_lo", md_if.lo_out, 32'h80000000);
    chk("ovf_hi", md_if.hi_out, 32'h0);

    issue(MD_DIV, 32'd7, 32'hFFFFFFFE, 1'b0); wait_idle(n);
    chk("div_negd_lo", md_if.lo_out, 32'hFFFFFFFD);
    chk("div_negd_hi", md_if.hi_out, 32'd1);

    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); wait_idle(n);
    chk("multu_hi", md_if.hi_out, 32'hFFFFFFFE);
    chk("multu_lo", md_if.lo_out, 32'h00000001);

    issue(MD_DIVU, 32'hFFFFFFFF, 32'd10, 1'b0); wait_idle(n);
    chk("divu_big_lo", md_if.lo_out, 32'h19999999);
    chk("divu_big_hi", md_if.hi_out, 32'd5);

    issue(MD_NONE, 32'd1, 32'd1, 1'b0); wait_idle(n);
    chk("none_busy", n, 0);

    // req raised on the third busy cycle must not abort the divide.
    issue(MD_DIV, 32'd100, 32'd7, 1'b0);
    repeat (2) @(negedge clk);
    md_if.req = 1'b1;
    @(negedge clk);
    md_if.req = 1'b0;
    wait_idle(n);
    chk("req_mid_lo", md_if.lo_out, 32'd14);
    chk("req_mid_hi", md_if.hi_out, 32'd2);

    issue(MD_DIV, 32'd50, 32'd3, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_hi", md_if.hi_out, 32'h0);
    chk("rst_mid_lo", md_if.lo_out, 32'h0);
    chk("rst_mid_busy", {31'd0, md_if.busy}, 32'h0);

    issue(MD_MTHI, 32'hAA, 32'd0, 1'b0);
    issue(MD_MTLO, 32'hBB, 32'd0, 1'b0);
    issue(MD_DIV, 32'd5, 32'd0, 1'b0); wait_idle(n);
    chk("div0_cycles", n, DC);
    chk("div0_hi", md_if.hi_out, 32'hAA);
    chk("div0_lo", md_if.lo_out, 32'hBB);

    issue(MD_MTHI, 32'h0, 32'd0, 1'b0);
    issue(MD_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
    issue(MD_MADDU, 32'd1, 32'd1, 1'b0); wait_idle(n);
`ifdef MDU_MADD_EN
    chk("maddu_cycles", n, MC);
    chk("maddu_hi", md_if.hi_out, 32'd1);
    chk("maddu_lo", md_if.lo_out, 32'd0);
    issue(MD_MSUB, 32'd2, 32'hFFFFFFFF, 1'b0); wait_idle(n);
    chk("msub_hi", md_if.hi_out, 32'd1);
    chk("msub_lo", md_if.lo_out, 32'd2);
`else
    chk("maddu_cycles", n, 0);
    chk("maddu_hi", md_if.hi_out, 32'd0);
    chk("maddu_lo", md_if.lo_out, 32'hFFFFFFFF);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
